branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver.sv | 162 ++++++++++++++++
 tb/tb_branch_resolver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// In-order branch queue: trains predictor on resolve, flushes on mispredict.
// Optional BRANCH_RESOLVER_STATS_EN adds saturating branch/mispredict counters.
module branch_resolver #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [15:0] fetch_pc,
  input  logic        fetch_pred,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  input  logic [15:0] resolve_target,
  output logic        stall_fetch,
  output logic        br_instruction,
  output logic [15:0] mem_address,
  output logic        taken,
  output logic        not_taken,
  output logic        flush,
`ifdef BRANCH_RESOLVER_STATS_EN
  output logic [15:0] br_count,
  output logic [15:0] mispredict_count,
`endif
  output logic [15:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   pc_mem_q [DEPTH];
  logic          pred_mem_q [DEPTH];

  logic        br_q, br_d;
  logic [15:0] mem_q, mem_d;
  logic        tk_q, tk_d;
  logic        nt_q, nt_d;
  logic        flush_q, flush_d;
  logic [15:0] redir_q, redir_d;

  logic        pop, push, mispredict;
  logic [15:0] entry_pc;
  logic        entry_pred;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [15:0] brc_q, brc_d;
  logic [15:0] mpc_q, mpc_d;
`endif

  always_comb begin
    entry_pc   = pc_mem_q[rd_ptr_q];
    entry_pred = pred_mem_q[rd_ptr_q];
    pop        = (state_q == RUN) & resolve_valid
               & (count_q != '0);
    mispredict = pop & (entry_pred != resolve_taken);
    push       = (state_q == RUN) & fetch_valid
               & ((count_q != FULL) | pop) & ~mispredict;

    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    unique case (state_q)
      RUN:   if (mispredict) state_d = FLUSH;
      FLUSH: state_d = RUN;
      default: state_d = RUN;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A mispredict squashes everything younger than the resolving branch
    if (mispredict) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end

    br_d    = pop;
    mem_d   = pop ? entry_pc : mem_q;
    tk_d    = pop & resolve_taken;
    nt_d    = pop & ~resolve_taken;
    flush_d = mispredict;
    redir_d = redir_q;
    if (mispredict)
      redir_d = resolve_taken ? resolve_target
                              : entry_pc + 16'd2;

`ifdef BRANCH_RESOLVER_STATS_EN
    brc_d = brc_q;
    mpc_d = mpc_q;
    if (pop && brc_q != 16'hFFFF) brc_d = brc_q + 16'd1;
    if (mispredict && mpc_q != 16'hFFFF)
      mpc_d = mpc_q + 16'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      br_q     <= 1'b0;
      mem_q    <= '0;
      tk_q     <= 1'b0;
      nt_q     <= 1'b0;
      flush_q  <= 1'b0;
      redir_q  <= '0;
`ifdef BRANCH_RESOLVER_STATS_EN
      brc_q    <= '0;
      mpc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      br_q     <= br_d;
      mem_q    <= mem_d;
      tk_q     <= tk_d;
      nt_q     <= nt_d;
      flush_q  <= flush_d;
      redir_q  <= redir_d;
`ifdef BRANCH_RESOLVER_STATS_EN
      brc_q    <= brc_d;
      mpc_q    <= mpc_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc;
      pred_mem_q[wr_ptr_q] <= fetch_pred;
    end
  end

  assign stall_fetch    = (count_q == FULL) | (state_q == FLUSH);
  assign br_instruction = br_q;
  assign mem_address    = mem_q;
  assign taken          = tk_q;
  assign not_taken      = nt_q;
  assign flush          = flush_q;
  assign redirect_pc    = redir_q;
`ifdef BRANCH_RESOLVER_STATS_EN
  assign br_count         = brc_q;
  assign mispredict_count = mpc_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: queue-based reference model,
// directed scenarios followed by random traffic.
module tb_branch_resolver;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, fetch_valid, fetch_pred;
  logic        resolve_valid, resolve_taken;
  logic [15:0] fetch_pc, resolve_target;
  logic        stall_fetch, br_instruction;
  logic        taken, not_taken, flush;
  logic [15:0] mem_address, redirect_pc;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [15:0] br_count, mispredict_count;
`endif

  branch_resolver #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc),
    .fetch_pred(fetch_pred),
    .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken),
    .resolve_target(resolve_target),
    .stall_fetch(stall_fetch),
    .br_instruction(br_instruction),
    .mem_address(mem_address),
    .taken(taken),
    .not_taken(not_taken),
    .flush(flush),
`ifdef BRANCH_RESOLVER_STATS_EN
    .br_count(br_count),
    .mispredict_count(mispredict_count),
`endif
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        pred;
  } ent_t;

  typedef struct {
    logic        rst;
    logic        br;
    logic [15:0] mem;
    logic        tk;
    logic        nt;
    logic        fl;
    logic [15:0] redir;
    logic        stall;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  bit   m_flushing = 0;
  int   m_bc = 0;
  int   m_mc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: one call per clock, returns post-edge outputs
  task automatic model(input logic rst, input logic fv,
                       input logic [15:0] pc, input logic pr,
                       input logic rv, input logic rt,
                       input logic [15:0] tg);
    exp_t e;
    ent_t h;
    bit   mis;
    e = '{rst: rst, br: 0, mem: 0, tk: 0, nt: 0, fl: 0,
          redir: 0, stall: 0, bc: 0, mc: 0};
    if (rst) begin
      mq.delete();
      m_flushing = 0;
      m_bc = 0;
      m_mc = 0;
    end else if (m_flushing) begin
      m_flushing = 0;
    end else begin
      mis = 0;
      if (rv && mq.size() > 0) begin
        h = mq.pop_front();
        e.br = 1;
        e.mem = h.pc;
        e.tk = rt;
        e.nt = !rt;
        if (m_bc < 65535) m_bc++;
        if (h.pred != rt) begin
          mis = 1;
          e.fl = 1;
          e.redir = rt ? tg : 16'(h.pc + 16'd2);
          if (m_mc < 65535) m_mc++;
          mq.delete();
        end
      end
      if (fv && !mis && mq.size() < DEPTH)
        mq.push_back('{pc: pc, pred: pr});
      m_flushing = mis;
    end
    e.stall = (mq.size() == DEPTH) || m_flushing;
    e.bc = 16'(m_bc);
    e.mc = 16'(m_mc);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic rst, input logic fv,
                     input logic [15:0] pc, input logic pr,
                     input logic rv, input logic rt,
                     input logic [15:0] tg);
    @(negedge clk);
    reset          = rst;
    fetch_valid    = fv;
    fetch_pc       = pc;
    fetch_pred     = pr;
    resolve_valid  = rv;
    resolve_taken  = rt;
    resolve_target = tg;
    model(rst, fv, pc, pr, rv, rt, tg);
  endtask

  task automatic idle();
    cyc(0, 0, 16'h0, 0, 0, 0, 16'h0);
  endtask

  // Monitor: compare DUT against queued expectations after every edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("br_instruction", 32'(br_instruction), 32'(e.br));
        chk("taken", 32'(taken), 32'(e.tk));
        chk("not_taken", 32'(not_taken), 32'(e.nt));
        chk("flush", 32'(flush), 32'(e.fl));
        chk("stall_fetch", 32'(stall_fetch), 32'(e.stall));
        if (e.br || e.rst)
          chk("mem_address", 32'(mem_address), 32'(e.mem));
        if (e.fl || e.rst)
          chk("redirect_pc", 32'(redirect_pc), 32'(e.redir));
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("br_count", 32'(br_count), 32'(e.bc));
        chk("mispredict_count", 32'(mispredict_count),
            32'(e.mc));
`endif
      end
    end
  end

  initial begin
    logic [15:0] rpc, rtg;
    reset = 1;
    fetch_valid = 0;
    fetch_pc = 0;
    fetch_pred = 0;
    resolve_valid = 0;
    resolve_taken = 0;
    resolve_target = 0;

    cyc(1, 0, 16'h0, 0, 0, 0, 16'h0);
    cyc(1, 0, 16'h0, 0, 0, 0, 16'h0);
    idle();

    // correct taken prediction
    cyc(0, 1, 16'h3000, 1, 0, 0, 16'h0);
    cyc(0, 0, 16'h0, 0, 1, 1, 16'h4000);
    idle();

    // predicted not-taken, actually taken; fetch ignored in FLUSH
    cyc(0, 1, 16'h3010, 0, 0, 0, 16'h0);
    cyc(0, 0, 16'h0, 0, 1, 1, 16'h3100);
    cyc(0, 1, 16'h5555, 1, 1, 1, 16'h0);
    idle();

    // predicted taken, actually not taken
    cyc(0, 1, 16'h3020, 1, 0, 0, 16'h0);
    cyc(0, 0, 16'h0, 0, 1, 0, 16'h9999);
    idle();
    idle();

    // fill, overflow drop, push+pop while full, drain
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 16'(16'h3100 + 2 * i), 1, 0, 0, 16'h0);
    cyc(0, 1, 16'h3200, 1, 1, 1, 16'h0);
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 16'h0, 0, 1, 1, 16'h0);

    // wrap of pc+2 at the top of memory
    cyc(0, 1, 16'hFFFF, 1, 0, 0, 16'h0);
    cyc(0, 0, 16'h0, 0, 1, 0, 16'h0);
    idle();

    // resolve on empty, then reset during flush
    cyc(0, 0, 16'h0, 0, 1, 0, 16'h1234);
    cyc(0, 1, 16'h3030, 0, 0, 0, 16'h0);
    cyc(0, 0, 16'h0, 0, 1, 1, 16'h3300);
    cyc(1, 1, 16'h7777, 1, 1, 1, 16'h0);
    cyc(0, 1, 16'h3040, 1, 0, 0, 16'h0);
    cyc(0, 0, 16'h0, 0, 1, 1, 16'h0);
    idle();

    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 15) == 0) ? 16'hFFFF
                                         : 16'($urandom);
      rtg = 16'($urandom);
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 2) != 0), rpc,
          1'($urandom),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 3) != 0), rtg);
    end
    idle();

    for (int k = 0; k < 10 && exp_q.size() > 0; k++)
      @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0",
               exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
